// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 scan constants and helpers.
// Sprite/background controllers use these values for position math.
package vga_timing_pkg;

  localparam int CNT_W = 10;
  localparam int VGA_CLK_DIV = 4;

  localparam int VGA_H_TOTAL = 800;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_VIS_START = 144;
  localparam int VGA_H_VIS_END = 784;

  localparam int VGA_V_TOTAL = 525;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_VIS_START = 35;
  localparam int VGA_V_VIS_END = 515;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
  } sync_t;

  function automatic logic in_window(
    input cnt_t v,
    input cnt_t lo,
    input cnt_t hi
  );
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Reset-to-one shift register that retimes the sync pair.
// DEPTH of zero collapses to a plain wire.
module sync_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign o_q = i_d;
    end else begin : g_shift
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '1;
          end
        end else begin
          r_stage[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-scan timing source: counters, visible-window decode,
// delayable syncs and line/frame event pulses.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = VGA_CLK_DIV,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_VIS_START = VGA_H_VIS_START,
  parameter int H_VIS_END   = VGA_H_VIS_END,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_VIS_START = VGA_V_VIS_START,
  parameter int V_VIS_END   = VGA_V_VIS_END,
  parameter int SYNC_DELAY  = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             bright,
  output logic             hSync,
  output logic             vSync,
  output logic             pix_en,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_count
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE = DIV_W'(CLK_DIV - 2);

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_SYNC_C = cnt_t'(H_SYNC);
  localparam cnt_t V_SYNC_C = cnt_t'(V_SYNC);
  localparam cnt_t H_VIS_S = cnt_t'(H_VIS_START);
  localparam cnt_t H_VIS_E = cnt_t'(H_VIS_END);
  localparam cnt_t V_VIS_S = cnt_t'(V_VIS_START);
  localparam cnt_t V_VIS_E = cnt_t'(V_VIS_END);

  logic [DIV_W-1:0] r_div;
  logic             r_pix_en;
  logic             r_line_start;
  logic             r_frame_start;
  cnt_t             r_hcount;
  cnt_t             r_vcount;
  logic [7:0]       r_frame_count;

  logic  w_pre_pix;
  logic  w_h_last;
  logic  w_v_last;
  sync_t w_sync_raw;
  sync_t w_sync_q;

  // Counters only move on pix_en edges, so the cycle before pix_en
  // already sees the values the pulses must be decoded from.
  assign w_pre_pix = (r_div == DIV_PRE);
  assign w_h_last = (r_hcount == H_LAST);
  assign w_v_last = (r_vcount == V_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div         <= '0;
      r_pix_en      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_frame_count <= '0;
    end else begin
      r_div         <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      r_pix_en      <= w_pre_pix;
      r_line_start  <= w_pre_pix && w_h_last;
      r_frame_start <= w_pre_pix && w_h_last && w_v_last;
      if (r_pix_en) begin
        if (w_h_last) begin
          r_hcount <= '0;
          if (w_v_last) begin
            r_vcount      <= '0;
            r_frame_count <= r_frame_count + 1'b1;
          end else begin
            r_vcount <= r_vcount + 1'b1;
          end
        end else begin
          r_hcount <= r_hcount + 1'b1;
        end
      end
    end
  end

  assign w_sync_raw.hsync = ~(r_hcount < H_SYNC_C);
  assign w_sync_raw.vsync = ~(r_vcount < V_SYNC_C);

  sync_delay_line #(
    .WIDTH(2),
    .DEPTH(SYNC_DELAY)
  ) u_sync_dly (
    .clk(clk),
    .rst(rst),
    .i_d(w_sync_raw),
    .o_q(w_sync_q)
  );

  assign hCount      = r_hcount;
  assign vCount      = r_vcount;
  assign pix_en      = r_pix_en;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;
  assign hSync       = w_sync_q.hsync;
  assign vSync       = w_sync_q.vsync;
  assign bright      = in_window(r_hcount, H_VIS_S, H_VIS_E)
                    && in_window(r_vcount, V_VIS_S, V_VIS_E);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed checks of vga_timing_gen on full and reduced geometries.
// Three instances share clk/rst: default, mid-size, tiny.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] d_hc, d_vc, a_hc, a_vc, b_hc, b_vc;
  logic d_br, d_hs, d_vs, d_pix, d_ls, d_fs;
  logic a_br, a_hs, a_vs, a_pix, a_ls, a_fs;
  logic b_br, b_hs, b_vs, b_pix, b_ls, b_fs;
  logic [7:0] d_fc, a_fc, b_fc;

  vga_timing_gen u_d (
    .clk(clk), .rst(rst), .hCount(d_hc), .vCount(d_vc),
    .bright(d_br), .hSync(d_hs), .vSync(d_vs), .pix_en(d_pix),
    .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(4), .H_TOTAL(20), .H_SYNC(4), .H_VIS_START(6),
    .H_VIS_END(18), .V_TOTAL(8), .V_SYNC(2), .V_VIS_START(3),
    .V_VIS_END(7), .SYNC_DELAY(2)
  ) u_a (
    .clk(clk), .rst(rst), .hCount(a_hc), .vCount(a_vc),
    .bright(a_br), .hSync(a_hs), .vSync(a_vs), .pix_en(a_pix),
    .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(10), .H_SYNC(2), .H_VIS_START(3),
    .H_VIS_END(9), .V_TOTAL(5), .V_SYNC(1), .V_VIS_START(2),
    .V_VIS_END(4), .SYNC_DELAY(3)
  ) u_b (
    .clk(clk), .rst(rst), .hCount(b_hc), .vCount(b_vc),
    .bright(b_br), .hSync(b_hs), .vSync(b_vs), .pix_en(b_pix),
    .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
  );

  typedef struct {
    int k;
    bit pix;
    int hc;
    bit hs;
    bit vs;
    bit ls;
  } vec_t;

  vec_t tv [12];
  int n_chk = 0;
  int n_fail = 0;
  int s_br, s_br4, s_bad, s_mod, s_vs, s_hs, s_ls, s_fs, s_pix;
  int fs_h, fs_v, fc0, t, hs_low, ls_cnt;
  bit m;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_a_reset(input string tag);
    chk({tag, " a_hc"}, a_hc, 0);
    chk({tag, " a_vc"}, a_vc, 0);
    chk({tag, " a_pix"}, a_pix, 0);
    chk({tag, " a_ls"}, a_ls, 0);
    chk({tag, " a_fs"}, a_fs, 0);
    chk({tag, " a_fc"}, a_fc, 0);
    chk({tag, " a_br"}, a_br, 0);
    chk({tag, " a_hs"}, a_hs, 1);
    chk({tag, " a_vs"}, a_vs, 1);
    chk({tag, " b_hs"}, b_hs, 1);
    chk({tag, " d_hs"}, d_hs, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{1,  0, 0, 0, 0, 0};
    tv[1]  = '{2,  0, 0, 0, 0, 0};
    tv[2]  = '{3,  1, 0, 0, 0, 0};
    tv[3]  = '{4,  0, 1, 0, 0, 0};
    tv[4]  = '{5,  0, 1, 0, 0, 0};
    tv[5]  = '{6,  0, 1, 0, 0, 0};
    tv[6]  = '{7,  1, 1, 0, 0, 0};
    tv[7]  = '{8,  0, 2, 0, 0, 0};
    tv[8]  = '{9,  0, 2, 0, 0, 0};
    tv[9]  = '{10, 0, 2, 0, 0, 0};
    tv[10] = '{11, 1, 2, 0, 0, 0};
    tv[11] = '{12, 0, 3, 0, 0, 0};

    step();
    step();
    chk("rst d_hc", d_hc, 0);
    chk("rst d_vc", d_vc, 0);
    chk("rst d_pix", d_pix, 0);
    chk("rst d_hs", d_hs, 1);
    chk("rst d_vs", d_vs, 1);
    chk("rst d_br", d_br, 0);
    chk("rst d_fc", d_fc, 0);
    chk_a_reset("rst0");
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("t1 k%0d pix", tv[i].k), d_pix, tv[i].pix);
      chk($sformatf("t1 k%0d hc", tv[i].k), d_hc, tv[i].hc);
      chk($sformatf("t1 k%0d hs", tv[i].k), d_hs, tv[i].hs);
      chk($sformatf("t1 k%0d vs", tv[i].k), d_vs, tv[i].vs);
      chk($sformatf("t1 k%0d ls", tv[i].k), d_ls, tv[i].ls);
    end

    hs_low = 0;
    ls_cnt = 0;
    for (int k = 13; k <= 3212; k++) begin
      step();
      if (!d_hs) hs_low++;
      if (d_ls) ls_cnt++;
      if (k == 99) chk("b first frame_start", b_fs, 1);
      if (k == 100) chk("b frame_count 1", b_fc, 1);
      if (k == 639) begin
        chk("a frame_start", a_fs, 1);
        chk("a fs hc", a_hc, 19);
        chk("a fs vc", a_vc, 7);
      end
      if (k == 640) begin
        chk("a frame_count 1", a_fc, 1);
        chk("a wrap hc", a_hc, 0);
        chk("a wrap vc", a_vc, 0);
      end
      if (k == 3199) begin
        chk("d line_start", d_ls, 1);
        chk("d ls hc", d_hc, 799);
        chk("d ls vc", d_vc, 0);
      end
      if (k == 3200) begin
        chk("d wrap hc", d_hc, 0);
        chk("d wrap vc", d_vc, 1);
      end
    end
    chk("d hsync low clks", hs_low, 384);
    chk("d line_start count", ls_cnt, 1);
    chk("d end hc", d_hc, 3);
    chk("d end vc", d_vc, 1);

    t = 0;
    while (!a_fs && t < 700) begin
      step();
      t++;
    end
    chk("a frame_start reached", a_fs, 1);
    step();
    fc0 = a_fc;
    s_br = 0; s_br4 = 0; s_bad = 0; s_mod = 0; s_vs = 0;
    s_hs = 0; s_ls = 0; s_fs = 0; s_pix = 0; fs_h = -1; fs_v = -1;
    for (int i = 0; i < 640; i++) begin
      m = (a_hc >= 6) && (a_hc < 18) && (a_vc >= 3) && (a_vc < 7);
      if (m != a_br) s_mod++;
      if (a_br) s_br++;
      if (a_br && a_vc == 4) s_br4++;
      if (a_br && (a_hc == 5 || a_hc == 18 || a_vc == 2 || a_vc == 7))
        s_bad++;
      if (!a_vs) s_vs++;
      if (!a_hs) s_hs++;
      if (a_ls) s_ls++;
      if (a_pix) s_pix++;
      if (a_fs) begin
        s_fs++;
        fs_h = a_hc;
        fs_v = a_vc;
      end
      step();
    end
    chk("a bright total", s_br, 192);
    chk("a bright line4", s_br4, 48);
    chk("a bright edges", s_bad, 0);
    chk("a bright decode", s_mod, 0);
    chk("a vsync low clks", s_vs, 160);
    chk("a hsync low clks", s_hs, 128);
    chk("a line_start count", s_ls, 8);
    chk("a pix_en count", s_pix, 160);
    chk("a frame_start count", s_fs, 1);
    chk("a fs at hc", fs_h, 19);
    chk("a fs at vc", fs_v, 7);
    chk("a frame_count inc", a_fc, (fc0 + 1) & 255);
    chk("a frame hc0", a_hc, 0);
    chk("a frame vc0", a_vc, 0);

    t = 0;
    while (b_fc != 8'd255 && t < 30000) begin
      step();
      t++;
    end
    chk("b fc 255 reached", b_fc, 255);
    t = 0;
    while (!b_fs && t < 150) begin
      step();
      t++;
    end
    chk("b fs reached", b_fs, 1);
    chk("b fs fc", b_fc, 255);
    chk("b fs hc", b_hc, 9);
    chk("b fs vc", b_vc, 4);
    step();
    chk("b fc wrap", b_fc, 0);
    chk("b wrap hc", b_hc, 0);
    chk("b wrap vc", b_vc, 0);
    chk("b fs one clk", b_fs, 0);

    t = 0;
    while (!(a_hc == 10 && a_vc == 5) && t < 700) begin
      step();
      t++;
    end
    chk("a mid-line reached", (a_hc == 10 && a_vc == 5), 1);
    rst = 1'b1;
    #1;
    chk_a_reset("rst async");
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a_reset($sformatf("rst hold%0d", i));
    end
    rst = 1'b0;

    for (int k = 1; k <= 24; k++) begin
      step();
      chk($sformatf("r k%0d a_pix", k), a_pix, (k % 4) == 3);
      chk($sformatf("r k%0d a_hc", k), a_hc, k / 4);
      chk($sformatf("r k%0d a_hs", k), a_hs,
          (k < 2) ? 1 : (((k - 2) / 4) >= 4));
      chk($sformatf("r k%0d b_hs", k), b_hs,
          (k < 3) ? 1 : ((((k - 3) / 2) % 10) >= 2));
      chk($sformatf("r k%0d b_vs", k), b_vs,
          (k < 3) ? 1 : (((k - 3) / 20) >= 1));
      chk($sformatf("r k%0d b_ls", k), b_ls, k == 19);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
